ps2_key_decoder: RTL

//   Consumer stage directly downstream of ps2_keyboard: pops raw scan-code bytes from the keyboard FIFO.

---
 rtl/ps2_key_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// Pops set-2 scan codes from the keyboard FIFO and tracks the held key, its ASCII code, a press counter and FIFO overflow.
// One byte per 2+SETTLE cycles; outputs update one cycle after POP; the block pops only when kbd_ready is high.
module ps2_key_decoder #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             key_valid,
    output logic             key_event,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_seen
);

    typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_SETTLE} state_t;

    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [SCNT_W-1:0] settle_cnt;
    logic [7:0]        byte_q;
    logic              ext_pend;
    logic              brk_pend;
    logic              same_key;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
        logic [7:0] a;
        a = 8'h00;
        case (sc)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SCNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (kbd_ready) state_nxt = ST_POP;
            ST_POP:    state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SCNT_W'(SETTLE - 1)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        kbd_nextdata_n = (state != ST_POP);
    end

    // A make or break only matches the held key if the E0 prefix state also matches.
    assign same_key = key_valid && (byte_q == key_code) && (ext_pend == key_ext);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            byte_q    <= 8'h00;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_ascii <= 8'h00;
            key_valid <= 1'b0;
            key_event <= 1'b0;
            press_cnt <= '0;
            ovf_seen  <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (kbd_overflow)
                ovf_seen <= 1'b1;
            if (state == ST_IDLE && kbd_ready)
                byte_q <= kbd_data;
            if (state == ST_POP) begin
                case (byte_q)
                    8'hE0: ext_pend <= 1'b1;
                    8'hF0: brk_pend <= 1'b1;
                    8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                    default: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (brk_pend) begin
                            if (same_key)
                                key_valid <= 1'b0;
                        end else if (!same_key) begin
                            key_code  <= byte_q;
                            key_ext   <= ext_pend;
                            key_valid <= 1'b1;
                            key_ascii <= ext_pend ? 8'h00 : scan_to_ascii(byte_q);
                            key_event <= 1'b1;
                            press_cnt <= press_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
